// File: rtl/multu_sequencer_pkg.sv
// Shared definitions for the MULTU sequencer: FSM encoding and default sizing.
package multu_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

endpackage : multu_sequencer_pkg

// File: rtl/multu_sequencer_step.sv
// One radix-2 shift-add step of the unsigned multiply: conditionally add the
// multiplicand into the accumulator, then shift {acc, mplier} right by one.
module multu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0]   acc_nx,
  output logic [WIDTH-1:0] mplier_nx
);

  logic [WIDTH:0] sum;

  // Add then shift; the carry bit of sum lands in the accumulator MSB-1,
  // and the accumulator MSB always refills with zero so no carry is lost.
  always_comb begin
    sum       = acc + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nx    = {1'b0, sum[WIDTH:1]};
    mplier_nx = {sum[0], mplier[WIDTH-1:1]};
  end

endmodule : multu_step

// File: rtl/multu_sequencer.sv
// Iterative MULTU controller: owns HI/LO, runs a WIDTH-step shift-add loop,
// and stalls MFHI/MFLO while a product is still being formed.
module multu_sequencer
  import multu_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic           done_q, done_d;

  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] mplier_nx;

  multu_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_q),
    .mplier    (mplier_q),
    .mcand     (mcand_q),
    .acc_nx    (acc_nx),
    .mplier_nx (mplier_nx)
  );

  // Next-state logic: step while running, commit on the last step, and let a
  // new start (re)load operands regardless of state; a commit in the same
  // edge as a start still completes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    if (state_q == RUN) begin
      acc_d    = acc_nx;
      mplier_d = mplier_nx;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        hi_d    = acc_nx[WIDTH-1:0];
        lo_d    = mplier_nx;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = RUN;
    end
  end

  // State, datapath and HI/LO registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Outputs; stall is purely combinational so the read is held in-cycle.
  always_comb begin
    busy  = (state_q == RUN);
    stall = busy & hilo_rd;
    done  = done_q;
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule : multu_sequencer

// File: doc/multu_sequencer.md
# multu_sequencer

Iterative controller for the MIPS `MULTU` instruction.
- Computes the unsigned 2·WIDTH-bit product with a radix-2 shift-add loop over WIDTH cycles.
- Owns the HI/LO registers and stalls the core while an `MFHI`/`MFLO` waits on an unfinished product.
- Sits beside the ALU in the processor datapath, driven by the main decoder.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  `MULTU` issued this cycle; a/b are valid.
- a  in  WIDTH  multiplicand (rs).
- b  in  WIDTH  multiplier (rt).
- hilo_rd  in  1  `MFHI`/`MFLO` is in the current cycle.
- hi  out  WIDTH  HI register (upper product half).
- lo  out  WIDTH  LO register (lower product half).
- busy  out  1  a multiplication is in progress.
- done  out  1  one-cycle pulse: hi/lo were just committed.
- stall  out  1  freeze the PC and the register-file write this cycle.

## Operation
- States: IDLE, RUN.
- IDLE, start=1: at the next edge
  - mcand←a, mplier←b, acc (WIDTH+1 bits, carry included)←0, cnt←0
  - go to RUN, busy←1.
- RUN, each edge, one step:
  - sum = acc + (mplier[0] ? mcand : 0)
  - shift {sum, mplier} right by 1; the LSB of sum enters mplier[WIDTH-1]
  - cnt←cnt+1
- RUN, on the step where cnt = WIDTH-1:
  - hi←final upper half, lo←final lower half
  - busy←0, done←1 for the following cycle, return to IDLE.
- Arithmetic is unsigned only and cannot overflow; the acc carry bit absorbs the addition carry.
- stall = busy & hilo_rd, combinational. No other stall source.
- hi/lo change only on commit or reset. While busy they hold the previous product.
- start while busy (RUN): abort and restart with the new a/b at that edge. cnt←0, hi/lo untouched, no done for the aborted op.
- start and hilo_rd in the same IDLE cycle: no stall; the read returns the old hi/lo.
- start in the commit cycle (cnt = WIDTH-1):
  - the commit completes (hi/lo written, done pulses)
  - a new RUN begins in the same edge with the new operands.
- Reset (asynchronous, any state):
  - state=IDLE
  - hi=0, lo=0, busy=0, done=0, stall=0
  - cnt=0, acc=0, mcand=0, mplier=0.

## Timing
- start sampled at edge E0: busy=1 from after E0 through the cycle before edge E0+WIDTH.
- hi/lo updated at edge E0+WIDTH. Latency is WIDTH+1 cycles, counting the start cycle.
- done high exactly in the cycle after E0+WIDTH. busy is 0 in that cycle unless restarted.
- stall is combinational, valid within the same cycle as hilo_rd; no registered delay.
- An `MFHI`/`MFLO` stalled in cycle E0+WIDTH-1 proceeds in the next cycle and reads the new product.
- Throughput: one multiply per WIDTH cycles. Back-to-back via the commit-cycle start is allowed.

## Structure
- Shared package/include holds:
  - state encodings: IDLE=1'b0, RUN=1'b1
  - default WIDTH localparam (32)
  - counter width CNT_W = $clog2(WIDTH).
- One natural sub-module: `multu_step` (combinational). Takes acc, mplier, mcand; returns the shifted next acc/mplier. Keeps the FSM/register logic separate from the add/shift.
- Top holds the FSM, cnt, operand/accumulator registers, HI/LO registers and the stall logic.

## Test plan
- Small operands:
  - reset, then start with a=3, b=5
  - required: busy for 32 cycles; done in cycle 33; hi=00000000, lo=0000000F.
- Maximum operands: a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001; no carry loss.
- Stall:
  - a=00010000, b=00010000, hilo_rd held high from the cycle after start
  - required: stall=1 for exactly 32 cycles, then 0 with hi=00000001, lo=00000000.
- Reset mid-operation:
  - start a=7, b=9; assert reset asynchronously at cycle 10
  - required: immediately hi=lo=0, busy=0, stall=0; no done pulse afterwards.
- Restart mid-operation:
  - prior product 3·5 committed; start a=2, b=2, then start a=6, b=7 at cycle 5
  - required: hi/lo stay 0/0000000F until the second op commits 32 cycles after its start, then lo=0000002A; exactly one done pulse.
- Commit-cycle restart:
  - start a=4, b=4 exactly in the cycle where cnt=31 of a 3·5 operation
  - required: lo=0000000F with done, then lo=00000010 32 cycles later.
